// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one uart_tx transmitter among N_REQ byte producers.
// Each grant runs one full frame: latch the byte, pulse update for two
// cycles, wait for busy to rise (with timeout), wait for busy to fall, ack.
// Optional build macro UART_TX_SCHED_FIXED_PRIO_EN: when defined, the search
// for the next requester always starts at bit 0 (fixed priority); when
// undefined, a round-robin pointer starts the search after the last owner.
module uart_tx_sched #(
   parameter int N_REQ        = 4,
   parameter int GAP_CYCLES   = 16,
   parameter int BUSY_TIMEOUT = 31
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   ack,
   output logic [N_REQ-1:0]   grant,
   output logic [7:0]         tx_data,
   output logic               tx_update,
   input  logic               tx_busy,
   output logic               active,
   output logic               err
);

   localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [7:0]         data_q, data_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   start_ptr;
   logic [N_REQ-1:0]   sel;

   // First set request bit at or after 'start', wrapping modulo N_REQ.
   function automatic logic [N_REQ-1:0] pick(input logic [N_REQ-1:0] r,
                                              input logic [PTR_W-1:0] start);
      logic [N_REQ-1:0] g;
      int j;
      g = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = (int'(start) + k) % N_REQ;
         if (r[j]) begin
            g    = '0;
            g[j] = 1'b1;
         end
      end
      return g;
   endfunction

   // Byte lane selected by a one-hot owner vector.
   function automatic logic [7:0] lane(input logic [N_REQ-1:0] g,
                                       input logic [8*N_REQ-1:0] d);
      logic [7:0] b;
      b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (g[i]) b = b | d[8*i +: 8];
      end
      return b;
   endfunction

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
   assign start_ptr = '0;
`else
   logic [PTR_W-1:0] ptr_q, ptr_d;

   // Pointer value that follows a one-hot owner: (owner + 1) mod N_REQ.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [N_REQ-1:0] g);
      logic [PTR_W-1:0] p;
      p = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (g[i]) p = PTR_W'((i + 1) % N_REQ);
      end
      return p;
   endfunction

   assign start_ptr = ptr_q;

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
`endif

   assign sel = pick(req, start_ptr);

   // Next-state and registered-output logic of the frame sequencer.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      data_d  = data_q;
      ack_d   = '0;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            // The ack cycle is dead so a requester can drop req after ack
            // without being regranted.
            if ((|req) && (ack_q == '0)) begin
               grant_d = sel;
               data_d  = lane(sel, req_data);
               state_d = S_LOAD;
            end
         end
         S_LOAD: state_d = S_HOLD;
         S_HOLD: begin
            cnt_d   = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
               // Transmitter never started: flag it and retry from IDLE with
               // the pointer untouched so the same requester wins again.
               err_d   = 1'b1;
               grant_d = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               ack_d   = grant_q;
               grant_d = '0;
               cnt_d   = '0;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
               ptr_d   = next_ptr(grant_q);
`endif
               state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            if (cnt_q == CNT_W'(GAP_CYCLES)) state_d = S_IDLE;
            else                             cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, owner, byte, pulse and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         ack_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ack       = ack_q;
   assign grant     = grant_q;
   assign tx_data   = data_q;
   assign err       = err_q;
   assign tx_update = (state_q == S_LOAD) || (state_q == S_HOLD);
   assign active    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a behavioural uart_tx stand-in produces busy and
// reassembles the byte from tx_data bit by bit; a queue-free arbitration
// model predicts which requester is acknowledged next.
module tb_uart_tx_sched;
   localparam int N   = 4;
   localparam int GAP = 16;
   localparam int TO  = 31;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   ack, grant;
   logic [7:0]     tx_data;
   logic           tx_update, tx_busy, active, err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ptr_m = 0;
   int order_q[$];

   uart_tx_sched #(.N_REQ(N), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
      .ack(ack), .grant(grant), .tx_data(tx_data), .tx_update(tx_update),
      .tx_busy(tx_busy), .active(active), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- uart_tx stand-in ----------------
   logic       busy_en = 1'b1;
   logic       busy_glitch = 1'b0;
   logic       m_busy, m_prev;
   logic [1:0] m_phase;
   logic [7:0] m_cnt, m_shift, m_byte;

   assign tx_busy = m_busy | busy_glitch;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_prev <= 1'b0; m_phase <= 2'd0;
         m_cnt <= '0; m_shift <= '0; m_byte <= '0;
      end else begin
         m_prev <= tx_update;
         case (m_phase)
            2'd0: if (tx_update && !m_prev && busy_en) begin
               m_phase <= 2'd1; m_cnt <= '0;
            end
            2'd1: begin
               if (m_cnt == 8'd3) begin
                  m_busy <= 1'b1; m_phase <= 2'd2; m_cnt <= '0;
               end else m_cnt <= m_cnt + 8'd1;
            end
            default: begin
               // start bit, 8 data bits LSB first, stop bit; 16 clocks each
               if (m_cnt[3:0] == 4'd0 && m_cnt >= 8'd16 && m_cnt <= 8'd128)
                  m_shift[m_cnt[7:4] - 4'd1] <= tx_data[m_cnt[7:4] - 4'd1];
               if (m_cnt == 8'd159) begin
                  m_busy <= 1'b0; m_phase <= 2'd0; m_byte <= m_shift;
               end else m_cnt <= m_cnt + 8'd1;
            end
         endcase
      end
   end

   // Next owner per the arbitration rule: first pending bit from the pointer.
   function automatic int pick_m(input logic [N-1:0] pend, input int p);
      int s;
      s = p;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
      s = 0;
`endif
      for (int k = 0; k < N; k++) if (pend[(s + k) % N]) return (s + k) % N;
      return -1;
   endfunction

   task automatic wait_grant(input int lim, output bit ok);
      int t = 0;
      do begin @(negedge clk); t++; end while (grant == '0 && t < lim);
      ok = (grant != '0);
   endtask

   task automatic wait_ack(input int lim, output bit ok);
      int t = 0;
      do begin @(negedge clk); t++; end while (ack == '0 && t < lim);
      ok = (ack != '0);
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((active || ack != '0) && t < 200) begin @(negedge clk); t++; end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1; ptr_m = 0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      total++; if (ack !== '0)     begin bad++; $display("FAIL rst_ack got=%b want=0", ack); end
      total++; if (grant !== '0)   begin bad++; $display("FAIL rst_grant got=%b want=0", grant); end
      total++; if (tx_data !== '0) begin bad++; $display("FAIL rst_txdata got=%h want=0", tx_data); end
      total++; if ({tx_update, active, err} !== 3'b000)
         begin bad++; $display("FAIL rst_ctl got upd/act/err=%b want=000", {tx_update, active, err}); end
      rst_n = 1'b1; ptr_m = 0;
      @(negedge clk);
   endtask

   task automatic test_single();
      bit ok; int n;
      wait_idle();
      req_data = {$urandom, $urandom};
      req_data[15:8] = 8'hA5;
      req = 4'b0010;
      wait_grant(10, ok);
      total++; if (!ok) begin bad++; $display("FAIL single_grant_wait got=none want=grant"); end
      total++; if (grant !== 4'b0010) begin bad++; $display("FAIL single_grant got=%b want=0010", grant); end
      total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_txdata got=%h want=a5", tx_data); end
      n = 0;
      while (tx_update && n < 10) begin n++; @(negedge clk); end
      total++; if (n !== 2) begin bad++; $display("FAIL single_upd_width got=%0d want=2", n); end
      wait_ack(400, ok);
      total++; if (ack !== 4'b0010) begin bad++; $display("FAIL single_ack got=%b want=0010", ack); end
      total++; if (m_byte !== 8'hA5) begin bad++; $display("FAIL single_line got=%h want=a5", m_byte); end
      req = '0; ptr_m = 2;
      @(negedge clk);
      total++; if (ack !== '0) begin bad++; $display("FAIL single_ack_once got=%b want=0", ack); end
   endtask

   // All requesters in 'mask' hold req until acked; each ack is checked
   // against the arbitration model, the byte seen on the line, and spacing.
   task automatic run_batch(input logic [N-1:0] mask);
      logic [N-1:0] pend, ev;
      logic [8*N-1:0] dat;
      int t, e, last_ack;
      logic prev_upd;
      wait_idle();
      for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
      dat = req_data; pend = mask; req = mask;
      order_q.delete(); last_ack = -1; prev_upd = tx_update; t = 0;
      while (pend != '0 && t < 5000) begin
         @(negedge clk); t++;
         if (err) begin total++; bad++; $display("FAIL batch_err got=1 want=0"); end
         if (tx_update && !prev_upd && last_ack >= 0) begin
            total++;
            if (cyc - last_ack !== GAP + 2)
               begin bad++; $display("FAIL batch_gap got=%0d want=%0d", cyc - last_ack, GAP + 2); end
            last_ack = -1;
         end
         prev_upd = tx_update;
         if (ack != '0) begin
            e = pick_m(pend, ptr_m);
            ev = '0; ev[e] = 1'b1;
            total++; if (ack !== ev) begin bad++; $display("FAIL batch_ack got=%b want=%b", ack, ev); end
            total++; if (m_byte !== dat[8*e +: 8])
               begin bad++; $display("FAIL batch_byte got=%h want=%h", m_byte, dat[8*e +: 8]); end
            pend = pend & ~ack; req = req & ~ack;
            ptr_m = (e + 1) % N; order_q.push_back(e); last_ack = cyc;
         end
      end
      total++; if (pend != '0) begin bad++; $display("FAIL batch_timeout got=%b want=0", pend); end
      req = '0;
   endtask

   task automatic test_rr_order();
      int exp_o[3];
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
      exp_o = '{0, 1, 3};
`else
      exp_o = '{3, 0, 1};
`endif
      run_batch(4'b1011);
      total++; if (order_q.size() !== 3) begin bad++; $display("FAIL rr_count got=%0d want=3", order_q.size()); end
      else for (int i = 0; i < 3; i++) begin
         total++; if (order_q[i] !== exp_o[i])
            begin bad++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, order_q[i], exp_o[i]); end
      end
   endtask

   task automatic test_all_four();
      do_reset();
      run_batch(4'b1111);
      total++; if (order_q.size() !== 4) begin bad++; $display("FAIL all4_count got=%0d want=4", order_q.size()); end
      else for (int i = 0; i < 4; i++) begin
         total++; if (order_q[i] !== i)
            begin bad++; $display("FAIL all4_order[%0d] got=%0d want=%0d", i, order_q[i], i); end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) run_batch(4'($urandom_range(1, 15)));
   endtask

   task automatic test_timeout();
      bit ok; int g0, t, nack; logic [7:0] d;
      wait_idle();
      d = 8'($urandom); req_data[7:0] = d;
      busy_en = 1'b0; req = 4'b0001;
      wait_grant(10, ok);
      g0 = cyc; t = 0; nack = 0;
      while (!err && t < 80) begin @(negedge clk); t++; if (ack != '0) nack++; end
      total++; if (!err) begin bad++; $display("FAIL to_err got=none want=pulse"); end
      total++; if (cyc - g0 !== TO + 2)
         begin bad++; $display("FAIL to_time got=%0d want=%0d", cyc - g0, TO + 2); end
      total++; if (grant !== '0) begin bad++; $display("FAIL to_grant_clr got=%b want=0", grant); end
      total++; if (nack !== 0) begin bad++; $display("FAIL to_no_ack got=%0d want=0", nack); end
      busy_en = 1'b1;
      @(negedge clk);
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL to_regrant got=%b want=0001", grant); end
      wait_ack(400, ok);
      total++; if (ack !== 4'b0001) begin bad++; $display("FAIL to_retry_ack got=%b want=0001", ack); end
      total++; if (m_byte !== d) begin bad++; $display("FAIL to_retry_byte got=%h want=%h", m_byte, d); end
      req = '0; ptr_m = 1;
   endtask

   task automatic test_capture();
      bit ok; logic [7:0] d;
      wait_idle();
      d = 8'($urandom); req_data[31:24] = d;
      req = 4'b1000;
      wait_grant(10, ok);
      repeat (5) @(negedge clk);
      req_data[31:24] = ~d;
      wait_ack(400, ok);
      total++; if (ack !== 4'b1000) begin bad++; $display("FAIL cap_ack got=%b want=1000", ack); end
      total++; if (m_byte !== d) begin bad++; $display("FAIL cap_byte got=%h want=%h", m_byte, d); end
      req = '0; ptr_m = 0;
   endtask

   task automatic test_glitch();
      bit ok; int nbad;
      wait_idle();
      nbad = 0;
      busy_glitch = 1'b1;
      repeat (3) begin @(negedge clk); if (active || grant != '0 || ack != '0) nbad++; end
      busy_glitch = 1'b0;
      total++; if (nbad !== 0) begin bad++; $display("FAIL glitch_idle got=%0d want=0", nbad); end
      req_data[7:0] = 8'h3C; req = 4'b0001;
      wait_ack(400, ok);
      req = '0;
      busy_glitch = 1'b1;
      repeat (3) begin @(negedge clk); if (ack != '0 || grant != '0) nbad++; end
      busy_glitch = 1'b0;
      req_data[15:8] = 8'hC3; req = 4'b0010;
      wait_ack(400, ok);
      total++; if (nbad !== 0) begin bad++; $display("FAIL glitch_gap got=%0d want=0", nbad); end
      total++; if (ack !== 4'b0010) begin bad++; $display("FAIL glitch_next_ack got=%b want=0010", ack); end
      total++; if (m_byte !== 8'hC3) begin bad++; $display("FAIL glitch_next_byte got=%h want=c3", m_byte); end
      req = '0; ptr_m = 2;
   endtask

   task automatic test_reset_mid();
      bit ok; int nack, t; logic [7:0] d;
      wait_idle();
      d = 8'($urandom); req_data[23:16] = d;
      req = 4'b0100;
      wait_grant(10, ok);
      nack = 0;
      repeat (40) begin @(negedge clk); if (ack[2]) nack++; end
      rst_n = 1'b0;
      #1;
      total++; if ({ack, grant} !== '0) begin bad++; $display("FAIL mid_rst_ag got=%b want=0", {ack, grant}); end
      total++; if ({tx_data, tx_update, active, err} !== '0)
         begin bad++; $display("FAIL mid_rst_ctl got=%h want=0", {tx_data, tx_update, active, err}); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1; ptr_m = 0;
      wait_grant(10, ok);
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL mid_regrant got=%b want=0100", grant); end
      t = 0;
      while (t < 400 && nack == 0) begin @(negedge clk); t++; if (ack[2]) nack++; end
      @(negedge clk); if (ack[2]) nack++;
      total++; if (nack !== 1) begin bad++; $display("FAIL mid_ack_count got=%0d want=1", nack); end
      total++; if (m_byte !== d) begin bad++; $display("FAIL mid_byte got=%h want=%h", m_byte, d); end
      req = '0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_rr_order();
      test_all_four();
      test_random();
      test_timeout();
      test_capture();
      test_glitch();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one `uart_tx` transmitter among `N_REQ` byte producers. It sits between the producers (command handlers, status reporters, debug taps) and the `uart_tx` instance. It drives the transmitter's `datain`/`update` pins and watches its `busy` output. Each granted byte is sequenced through one complete frame before the requester is acknowledged.

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters, 2..8.
- `GAP_CYCLES`, 16 — idle cycles inserted after each frame before the next grant; 0 = none.
- `BUSY_TIMEOUT`, 31 — max cycles to wait for `tx_busy` rise after an update pulse, 1..255.

Ports:
- `clk`  in  1  — UART clock, the same clock as `uart_tx` (16 clocks per bit).
- `rst_n`  in  1  — asynchronous, active-low reset.
- `req`  in  N_REQ  — per-requester request level.
- `req_data`  in  8*N_REQ  — byte i on bits [8i+7:8i].
- `ack`  out  N_REQ  — one-cycle pulse on bit i when byte i's frame completes.
- `grant`  out  N_REQ  — one-hot, current owner; 0 when idle.
- `tx_data`  out  8  — to `uart_tx.datain`.
- `tx_update`  out  1  — to `uart_tx.update`.
- `tx_busy`  in  1  — from `uart_tx.busy`.
- `active`  out  1  — high in every state except IDLE.
- `err`  out  1  — one-cycle pulse on busy timeout.

## Operation
- Reset values: `ack`=0, `grant`=0, `tx_data`=0, `tx_update`=0, `active`=0, `err`=0, state=IDLE, rr pointer=0, counters=0.
- States and transitions:
  - IDLE: if any `req` bit is set, select the first set bit searching upward from the pointer, wrapping modulo N_REQ. Latch its byte into `tx_data`, set `grant`, go to LOAD.
  - LOAD: `tx_update`=1, go to HOLD.
  - HOLD: `tx_update`=1, go to WAIT_BUSY. The update pulse is exactly 2 cycles so that `uart_tx`'s edge detector sees a clean rise.
  - WAIT_BUSY: `tx_update`=0. If `tx_busy`=1, go to WAIT_DONE. If instead the counter reaches BUSY_TIMEOUT, pulse `err`, clear `grant`, leave the pointer unchanged and go to IDLE (retry).
  - WAIT_DONE: when `tx_busy`=0, pulse `ack[i]` and set pointer=(i+1) mod N_REQ. Then go to GAP, or to IDLE if GAP_CYCLES=0. `grant` clears in the same cycle.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- `tx_data` is held stable from LOAD until WAIT_DONE exits, because `uart_tx` samples `datain` bit by bit during the frame.
- Requester handshake: hold `req` high until `ack`. `req_data` is captured at grant; later changes are ignored. If `req` drops after grant, the frame still completes and `ack` still pulses. If `req` is still high in the cycle after `ack`, it is a new request.
- No `ack` is issued without a completed frame. `err` never coincides with `ack`.

## Timing
- `req` seen in IDLE at cycle T: `grant`/`tx_data` valid at T+1, `tx_update` high at T+1 and T+2, low at T+3.
- `uart_tx` raises `busy` about 4 cycles after the rising edge of `tx_update`; this is well inside the default timeout.
- `ack` fires 1 cycle after `tx_busy` is sampled low in WAIT_DONE.
- Back-to-back spacing from `ack` to the next `tx_update`: GAP_CYCLES+2 cycles.
- Simultaneous requests: exactly one grant per frame, in round-robin order. A requester waits at most N_REQ-1 frames.
- Reset asserted mid-frame: all outputs return to reset values immediately, and no `ack` is issued for the aborted byte.
- `tx_busy` glitching high while in IDLE or GAP is ignored.

## Configuration
- `UART_TX_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority; the search always starts at bit 0 and the pointer is unused. Requester 0 can starve the others.
  - Undefined (default): round-robin as described above.

## Test plan
- Single request: `req`=4'b0010 with byte 0xA5 on lane 1. Required: `grant`=0010, `tx_data`=0xA5, `tx_update` high for exactly 2 cycles, the `uart_tx` line shows 0xA5 LSB-first, `ack`=0010 pulses once after `busy` falls.
- All four requesting, holding `req` high until ack then dropping it: bytes go out in order 0,1,2,3. Each `ack` is followed by a 16-cycle gap, then the next `tx_update`.
- Pointer at 2 with `req`=4'b1011: grant order is 3,0,1. With `UART_TX_SCHED_FIXED_PRIO_EN` defined, the order is 0,1,3.
- `tx_busy` tied low: `err` pulses at WAIT_BUSY entry+31, there is no `ack`, and the same requester is regranted on retry.
- `rst_n` pulsed low mid-frame: all outputs go to 0 asynchronously. After release, the pending `req` is regranted with `ack` count still 0 for that byte.
- `req_data` changed 5 cycles after grant: the transmitted byte is the original captured value.
